// File: rtl/axil_reg4_pkg.sv
// Shared definitions for the four-register AXI4-Lite slave: register offsets,
// response code, FSM state types and byte-lane helpers.
package axil_reg4_pkg;

  localparam logic [3:0] ADDR_REG0 = 4'h0;
  localparam logic [3:0] ADDR_REG1 = 4'h4;
  localparam logic [3:0] ADDR_REG2 = 4'h8;
  localparam logic [3:0] ADDR_REG3 = 4'hC;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } r_state_t;

  // One-hot register select from the word index (address bits [3:2]).
  function automatic logic [3:0] reg_sel(input logic [1:0] idx);
    logic [3:0] sel;
    sel = 4'b0000;
    case (idx)
      ADDR_REG0[3:2]: sel = 4'b0001;
      ADDR_REG1[3:2]: sel = 4'b0010;
      ADDR_REG2[3:2]: sel = 4'b0100;
      ADDR_REG3[3:2]: sel = 4'b1000;
      default:        sel = 4'b0000;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_reg4_slave.sv
// AXI4-Lite slave with four 32-bit read/write registers and per-register write strobes.
// Optional: define AXIL_REG4_WSTRB_EN to honour WSTRB byte lanes on writes.
module axil_reg4_slave
  import axil_reg4_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]                      AWPROT,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]                      ARPROT,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  w_state_t w_state;
  r_state_t r_state;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [1:0]                    aw_idx_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;

  logic                          aw_hs, w_hs, ar_hs;
  logic                          commit_en;
  logic [1:0]                    commit_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

`ifdef AXIL_REG4_WSTRB_EN
  logic [C_S_AXI_DATA_WIDTH/8-1:0] w_strb_q;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] commit_strb;
`endif

  // Select the address/data that complete the write on this edge: each half
  // comes either from the live channel or from the copy held while waiting.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    commit_en   = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = w_data_q;
`ifdef AXIL_REG4_WSTRB_EN
    commit_strb = w_strb_q;
`endif
    unique case (w_state)
      W_IDLE: if (aw_hs && w_hs) begin
        commit_en   = 1'b1;
        commit_idx  = AWADDR[3:2];
        commit_data = WDATA;
`ifdef AXIL_REG4_WSTRB_EN
        commit_strb = WSTRB;
`endif
      end
      W_HAVE_ADDR: if (w_hs) begin
        commit_en   = 1'b1;
        commit_data = WDATA;
`ifdef AXIL_REG4_WSTRB_EN
        commit_strb = WSTRB;
`endif
      end
      W_HAVE_DATA: if (aw_hs) begin
        commit_en  = 1'b1;
        commit_idx = AWADDR[3:2];
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
      aw_idx_q <= '0;
      w_data_q <= '0;
`ifdef AXIL_REG4_WSTRB_EN
      w_strb_q <= '0;
`endif
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= RESP_OKAY;
          end else if (aw_hs) begin
            w_state  <= W_HAVE_ADDR;
            aw_idx_q <= AWADDR[3:2];
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
          end else if (w_hs) begin
            w_state  <= W_HAVE_DATA;
            w_data_q <= WDATA;
`ifdef AXIL_REG4_WSTRB_EN
            w_strb_q <= WSTRB;
`endif
            AWREADY  <= 1'b1;
            WREADY   <= 1'b0;
          end else begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        W_HAVE_ADDR: if (w_hs) begin
          w_state <= W_RESP;
          WREADY  <= 1'b0;
          BVALID  <= 1'b1;
          BRESP   <= RESP_OKAY;
        end
        W_HAVE_DATA: if (aw_hs) begin
          w_state <= W_RESP;
          AWREADY <= 1'b0;
          BVALID  <= 1'b1;
          BRESP   <= RESP_OKAY;
        end
        W_RESP: if (BREADY) begin
          w_state <= W_IDLE;
          BVALID  <= 1'b0;
          AWREADY <= 1'b1;
          WREADY  <= 1'b1;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the register file is only four words, so it is cleared on reset like any flop.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= commit_en ? reg_sel(commit_idx) : 4'b0000;
      if (commit_en) begin
`ifdef AXIL_REG4_WSTRB_EN
        regs_q[commit_idx] <= merge_bytes(regs_q[commit_idx], commit_data, commit_strb);
`else
        regs_q[commit_idx] <= commit_data;
`endif
      end
    end
  end

  // Read data is sampled from the pre-edge register value, so a same-edge
  // commit is seen only by a later read.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_VALID;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= regs_q[ARADDR[3:2]];
            RRESP   <= RESP_OKAY;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_VALID: if (RREADY) begin
          r_state <= R_IDLE;
          RVALID  <= 1'b0;
          ARREADY <= 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign reg0_o = regs_q[0];
  assign reg1_o = regs_q[1];
  assign reg2_o = regs_q[2];
  assign reg3_o = regs_q[3];

  // Protection and sub-word address bits carry no meaning here.
  logic unused_inputs;
`ifdef AXIL_REG4_WSTRB_EN
  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR, ARADDR};
`else
  assign unused_inputs = ^{AWPROT, ARPROT, AWADDR, ARADDR, WSTRB};
`endif

endmodule

// File: doc/axil_reg4_slave.md
AXIL_REG4_SLAVE -- requirements
Module: axil_reg4_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte-address width; the decode uses bits [3:2].
REQ-003 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ARESETN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports AWADDR in 4, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1.
REQ-006 SHALL have ports WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1.
REQ-007 SHALL have ports BRESP out 2, BVALID out 1, BREADY in 1.
REQ-008 SHALL have ports ARADDR in 4, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1.
REQ-009 SHALL have ports RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1.
REQ-010 SHALL have ports reg0_o through reg3_o, out 32 each: the live register contents for the audio fabric.
REQ-011 SHALL have port wr_pulse_o, out 4: a one-cycle strobe per register, asserted in the cycle after that register is committed.

Function
REQ-012 SHALL act as the AXI4-Lite responder with four 32-bit read/write registers: 0x0, 0x4, 0x8, 0xC map to reg0..reg3.
REQ-013 Write FSM SHALL use four states:
- W_IDLE, with AWREADY=WREADY=1.
- W_HAVE_ADDR, reached when only AW handshakes; AWREADY=0, WREADY=1.
- W_HAVE_DATA, reached when only W handshakes; AWREADY=1, WREADY=0.
- W_RESP, reached when both are held.
REQ-014 When AW and W handshake in the same cycle, the FSM SHALL go W_IDLE -> W_RESP directly.
REQ-015 Register commit SHALL occur on the cycle of entry to W_RESP, with BVALID=1 and BRESP=OKAY (2'b00) in that same cycle.
REQ-016 In W_RESP, AWREADY and WREADY SHALL be 0; BVALID SHALL hold until BREADY, then the FSM returns to W_IDLE; this gives at most one outstanding write.
REQ-017 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_VALID (ARREADY=0).
- On AR handshake, RDATA SHALL be latched from the register selected by ARADDR[3:2]; RVALID=1 and RRESP=OKAY the next cycle.
- RDATA and RVALID SHALL hold until RREADY.
REQ-018 The read and write FSMs SHALL be independent.
REQ-019 When an AR handshake and a commit to the same register fall in the same cycle, the read SHALL return the pre-write value.
REQ-020 Address bits [1:0] SHALL be ignored; no access produces SLVERR.
REQ-021 Channel outputs SHALL be registered; there is no combinational path from VALID to READY.
REQ-022 reg0_o..reg3_o SHALL update in the cycle after commit.

Reset
REQ-023 While ARESETN=0:
- AWREADY, WREADY, ARREADY, BVALID, RVALID SHALL be 0.
- BRESP, RRESP, RDATA SHALL be 0.
- reg0..reg3 SHALL be 0x00000000; wr_pulse_o SHALL be 0.
- Both FSMs SHALL be in IDLE.
REQ-024 The READY outputs SHALL go to 1 on the first edge after ARESETN rises.
REQ-025 Reset mid-transaction SHALL discard any held AW/W or pending B/R without committing it.

Configuration
REQ-026 Macro AXIL_REG4_WSTRB_EN, when defined, SHALL update only the byte lanes whose WSTRB bit is 1; WSTRB=0 commits nothing but still returns B OKAY and pulses wr_pulse_o.
REQ-027 Without AXIL_REG4_WSTRB_EN, all four bytes SHALL be written regardless of WSTRB.

Structure
REQ-028 A shared package axil_reg4_pkg SHALL hold:
- the address offset constants;
- the RESP_OKAY constant;
- the write-state and read-state enum typedefs.
REQ-029 The design SHALL be a single module with no sub-module.

Verification
REQ-030 Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back in order -> RDATA 0x1, 0x2, 0x3, 0x4; every BRESP and RRESP is 0; wr_pulse_o shows 0001, 0010, 0100, 1000.
REQ-031 W (0xCAFEF00D) presented 3 cycles before AW (0x8) -> FSM passes through W_HAVE_DATA; reg2_o=0xCAFEF00D; exactly one BVALID.
REQ-032 With WSTRB_EN defined: reg0=0x00000001, then write 0xAABBCCDD with WSTRB=4'b0101 -> reg0=0x00BB00DD. Without the macro -> reg0=0xAABBCCDD.
REQ-033 BREADY held low for 10 cycles after a write -> BVALID stays high; AWREADY and WREADY stay 0; a second AW is not accepted until the B handshake. Same check with RREADY low for reads.
REQ-034 Same-cycle AR and commit to 0x4 (old 0x2, new 0x9) -> RDATA=0x2; a subsequent read returns 0x9.
REQ-035 ARESETN pulled low while in W_HAVE_ADDR -> after release, all registers are 0, no BVALID, and the READY outputs are 1 one cycle after release.
